mips_run_monitor: RTL
=====================

# mips_run_monitor

Synthesizable run-control and result-readout unit for the single-cycle MIPS core. It watches the core's PC and ends a program run on any of three conditions: end address reached, PC stalled, or cycle budget exhausted. It then asserts a halt request and streams a parametrised window of data-memory words out over a valid/ready port. It is the parametrised hardware successor of the bench-side end-PC check and memory dump, usable both on the board and in benches.

## Interface

- PC_W, 32, width of PC
- ADDR_W, 8, data-memory word-address width
- DATA_W, 32, data-memory word width
- END_PC, 32'hA0, PC value that marks normal program end
- DUMP_BASE, 50, first word address dumped
- DUMP_CNT, 21, number of words dumped (0 allowed)
- STALL_CYC, 16, consecutive cycles of unchanged PC that count as a stall (≥2)
- MAX_CYC, 100000, cycle budget before timeout (≥1)
- CNT_W, 32, cycle counter width

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- pc_in  in  PC_W  core PC
- mem_addr  out  ADDR_W  data-memory read address
- mem_rdata  in  DATA_W  data-memory read data (combinational read of mem_addr)
- halt_req  out  1  request core to freeze
- pc_change  out  1  one-cycle pulse: PC differs from previous cycle
- dump_valid  out  1  dump word available
- dump_ready  in  1  sink accepts word
- dump_data  out  DATA_W  dumped word
- dump_index  out  ADDR_W  offset of dump_data within window (0..DUMP_CNT-1)
- done  out  1  run finished and dump complete
- cause  out  2  00 none, 01 end PC, 10 stall, 11 timeout
- cycle_count  out  CNT_W  cycles spent in RUN, saturating

## Operation

- States: RUN, LOAD, SEND, DONE. Reset enters RUN.
- RUN: cycle_count increments each cycle (saturating at all-ones). pc_q holds the previous PC. stall_cnt resets to 0 when pc_in != pc_q and increments otherwise.
- Exit conditions are evaluated on the current cycle. Priority: pc_in == END_PC → cause 01; else stall_cnt == STALL_CYC-1 with PC unchanged → 10; else cycle_count == MAX_CYC-1 → 11. On exit, cause and halt_req are registered.
- Exit goes to LOAD, or to DONE if DUMP_CNT == 0.
- LOAD: mem_addr = DUMP_BASE + idx. At the clock edge, mem_rdata is captured into dump_data, dump_index is set to idx, and the state goes to SEND.
- SEND: dump_valid = 1. dump_data and dump_index are held stable until dump_ready. On handshake with idx == DUMP_CNT-1, go to DONE. Otherwise idx increments and the state returns to LOAD.
- DONE: done = 1, halt_req = 1, dump_valid = 0. The block stays in DONE until reset.
- pc_change = registered (pc_in != pc_q). It is active in all states.
- Address arithmetic is modulo 2^ADDR_W. A window that runs past the top wraps to 0.

## Timing

- Reset values: halt_req 0, pc_change 0, dump_valid 0, dump_data 0, dump_index 0, mem_addr 0, done 0, cause 00, cycle_count 0, idx 0, stall_cnt 0. pc_q is loaded from pc_in on the first clocked cycle; no pc_change is asserted on that cycle.
- halt_req rises on the edge that leaves RUN and stays high until reset.
- Each word takes a minimum of 2 cycles (LOAD + SEND with ready high). Full dump is ≥ 2·DUMP_CNT cycles after exit.
- dump_valid must not drop without a handshake. Data is stable while valid && !ready.
- done rises on the edge after the last handshake.
- If END_PC and a stall or timeout condition occur on the same cycle, cause is 01.
- cycle_count freezes on leaving RUN.
- Asserting reset_n low mid-dump clears all state immediately. The run restarts in RUN after release.

## Test plan

- Program reaches PC 0xA0 at cycle 40, dump_ready tied 1 → cause 01; 21 words from addresses 50..70 with dump_index 0..20; done is high 42 cycles after exit; cycle_count = 40.
- PC held at 0x1C (self-loop), STALL_CYC=16 → cause 10 after 16 identical cycles; halt_req rises; dump follows.
- PC never reaches END_PC, MAX_CYC=200 → cause 11; cycle_count = 199 frozen.
- dump_ready toggles 1-0-0-1 pseudo-randomly → no word lost or duplicated; dump_data stable during stalls; indices are contiguous.
- DUMP_CNT=0 → DONE on the edge after exit; dump_valid is never asserted.
- reset_n pulsed low during the 5th SEND → outputs return to reset values asynchronously; a second run produces a full 21-word dump.

Source files
------------

// File: rtl/mips_run_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mips_run_monitor                                           |
// | Description : Run-control and result-readout unit for the single-cycle  |
// |               MIPS core. Ends a program run on end-PC, PC stall or       |
// |               cycle-budget timeout. It then raises halt_req and streams  |
// |               a window of data-memory words out over a valid/ready port. |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk          in   clock, all state on rising edge                      |
// |   reset_n      in   asynchronous active-low reset                        |
// |   pc_in        in   core PC                                              |
// |   mem_addr     out  data-memory read address (driven in LOAD)            |
// |   mem_rdata    in   data-memory read data, combinational on mem_addr     |
// |   halt_req     out  request core to freeze (high after the run ends)     |
// |   pc_change    out  registered "PC differs from previous cycle"          |
// |   dump_valid   out  dump word available                                 |
// |   dump_ready   in   sink accepts word                                    |
// |   dump_data    out  dumped word                                         |
// |   dump_index   out  offset of dump_data within the window                |
// |   done         out  run finished and dump complete                       |
// |   cause        out  00 none, 01 end PC, 10 stall, 11 timeout             |
// |   cycle_count  out  cycles spent in RUN, saturating                      |
// +--------------------------------------------------------------------------+
module mips_run_monitor #(
  parameter int              PC_W      = 32,
  parameter int              ADDR_W    = 8,
  parameter int              DATA_W    = 32,
  parameter logic [PC_W-1:0] END_PC    = PC_W'(32'hA0),
  parameter int              DUMP_BASE = 50,
  parameter int              DUMP_CNT  = 21,
  parameter int              STALL_CYC = 16,
  parameter int              MAX_CYC   = 100000,
  parameter int              CNT_W     = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [PC_W-1:0]   pc_in,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              halt_req,
  output logic              pc_change,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_index,
  output logic              done,
  output logic [1:0]        cause,
  output logic [CNT_W-1:0]  cycle_count
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  // The stall counter never has to hold more than STALL_CYC, so it is sized
  // to that rather than to the full cycle-counter width.
  localparam int                STALL_W    = $clog2(STALL_CYC + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYC - 1);
  localparam logic [CNT_W-1:0]  MAX_LAST   = CNT_W'(MAX_CYC - 1);
  localparam logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(DUMP_BASE);
  // An empty window skips the dump states, so LAST_IDX only matters when
  // DUMP_CNT is non-zero; clamp it to avoid a negative constant otherwise.
  localparam int                LAST_INT   = (DUMP_CNT > 0) ? DUMP_CNT - 1 : 0;
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(LAST_INT);
  localparam bit                HAS_DUMP   = (DUMP_CNT > 0);

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_END     = 2'b01;
  localparam logic [1:0] CAUSE_STALL   = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [PC_W-1:0]    pc_q;
  logic               pc_valid;   // pc_q holds a real sample (not the reset value)
  logic [STALL_W-1:0] stall_cnt;
  logic [ADDR_W-1:0]  idx;

  logic               pc_same;
  logic               hit_end;
  logic               hit_stall;
  logic               hit_timeout;
  logic               exit_run;
  logic [1:0]         exit_cause;

  // --------------------------------------------------------------------------
  // Exit detection (combinational, evaluated on the current cycle)
  // --------------------------------------------------------------------------
  // The first cycle after reset has no previous PC to compare against, so it
  // neither counts as a stall cycle nor produces a pc_change pulse.
  assign pc_same     = pc_valid && (pc_in == pc_q);
  assign hit_end     = (pc_in == END_PC);
  assign hit_stall   = pc_same && (stall_cnt == STALL_LAST);
  assign hit_timeout = (cycle_count == MAX_LAST);
  assign exit_run    = (state == ST_RUN) && (hit_end || hit_stall || hit_timeout);

  always_comb begin
    exit_cause = CAUSE_NONE;
    if (hit_end) begin
      exit_cause = CAUSE_END;
    end else if (hit_stall) begin
      exit_cause = CAUSE_STALL;
    end else if (hit_timeout) begin
      exit_cause = CAUSE_TIMEOUT;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and state-decoded outputs
  // --------------------------------------------------------------------------
  // halt_req is decoded from the registered state, so it rises on the edge
  // that leaves RUN and stays high in every later state.
  always_comb begin
    state_next = state;
    halt_req   = 1'b1;
    done       = 1'b0;
    dump_valid = 1'b0;
    mem_addr   = '0;
    unique case (state)
      ST_RUN: begin
        halt_req = 1'b0;
        if (exit_run) begin
          state_next = HAS_DUMP ? ST_LOAD : ST_DONE;
        end
      end
      ST_LOAD: begin
        // Address wraps modulo 2^ADDR_W for windows that run past the top.
        mem_addr   = BASE_ADDR + idx;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        dump_valid = 1'b1;
        if (dump_ready) begin
          state_next = (idx == LAST_IDX) ? ST_DONE : ST_LOAD;
        end
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // PC tracking (active in every state)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= '0;
      pc_valid  <= 1'b0;
      pc_change <= 1'b0;
    end else begin
      pc_q      <= pc_in;
      pc_valid  <= 1'b1;
      pc_change <= pc_valid && (pc_in != pc_q);
    end
  end

  // --------------------------------------------------------------------------
  // Run counters and exit cause
  // --------------------------------------------------------------------------
  // On the exit cycle the counters are left untouched so cycle_count reports
  // the value the exit condition was evaluated against.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_count <= '0;
      stall_cnt   <= '0;
      cause       <= CAUSE_NONE;
    end else if (state == ST_RUN) begin
      if (exit_run) begin
        cause <= exit_cause;
      end else begin
        if (cycle_count != {CNT_W{1'b1}}) begin
          cycle_count <= cycle_count + CNT_W'(1);
        end
        if (pc_same) begin
          stall_cnt <= stall_cnt + STALL_W'(1);
        end else begin
          stall_cnt <= '0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Dump datapath
  // --------------------------------------------------------------------------
  // dump_data / dump_index are only written in LOAD, which makes them stable
  // for the whole SEND phase regardless of how long the sink stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx        <= '0;
      dump_data  <= '0;
      dump_index <= '0;
    end else begin
      if (state == ST_LOAD) begin
        dump_data  <= mem_rdata;
        dump_index <= idx;
      end
      if ((state == ST_SEND) && dump_ready && (idx != LAST_IDX)) begin
        idx <= idx + ADDR_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
